// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational RV32I ALU between NREQ requesters.
// Each granted operation is registered, executed for one cycle, and its result returned over valid/ready.
module alu_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    input  logic [NREQ*5-1:0]    req_shamt,
    input  logic [NREQ-1:0]      req_sub_sra,
    input  logic [NREQ*4-1:0]    req_func,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [4:0]           alu_shamt,
    output logic                 alu_sub_sra,
    output logic [3:0]           alu_func,
    input  logic [XLEN-1:0]      alu_out,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      shamt;
        logic            sub_sra;
        logic [3:0]      func;
    } op_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_last;
    logic [IDW-1:0] winner;
    logic           found;
    logic           accept;
    op_t            op_q;
    op_t            op_sel;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [IDW-1:0] idx;
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(rr_last) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        op_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == winner) begin
                op_sel.a       = req_a[i*XLEN +: XLEN];
                op_sel.b       = req_b[i*XLEN +: XLEN];
                op_sel.shamt   = req_shamt[i*5 +: 5];
                op_sel.sub_sra = req_sub_sra[i];
                op_sel.func    = req_func[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_nxt         = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && found;
    assign busy   = (state != IDLE);

    // Operand, ownership and result registers; alu_* hold their value between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            owner    <= '0;
            rr_last  <= IDW'(NREQ - 1);
            rsp_data <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_sel;
                owner   <= winner;
                rr_last <= winner;
            end
            if (state == EXEC) begin
                rsp_data <= alu_out;
            end
        end
    end

    assign alu_a       = op_q.a;
    assign alu_b       = op_q.b;
    assign alu_shamt   = op_q.shamt;
    assign alu_sub_sra = op_q.sub_sra;
    assign alu_func    = op_q.func;

endmodule
